// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared definitions for the mux select sequencer:
//   - default geometry of the 31:1 x 2-bit input mux (NUM_INP, SEL_W, DATA_W)
//   - LAST_IDX, the highest select value that is ever driven
//   - state_t, the sequencer state encoding (IDLE, SCAN, DRAIN)
// -----------------------------------------------------------------------------
package mux_scan_pkg;

    localparam int NUM_INP  = 31;
    localparam int SEL_W    = 5;
    localparam int DATA_W   = 2;
    localparam int LAST_IDX = NUM_INP - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_seq_if.sv
// -----------------------------------------------------------------------------
// mux_scan_seq_if
// Bundles the mux-facing select/data pair and the downstream sample handshake.
//   sel        select driven to the mux
//   mux_out    combinational mux output for the current sel
//   smp_valid  sample register holds data
//   smp_ready  downstream accepts the sample
//   smp_data   sampled value
//   smp_idx    index the sample came from
// Modports:
//   master  the sequencer (drives sel and the sample, receives mux_out/ready)
//   slave   the environment (mux model + downstream consumer)
// -----------------------------------------------------------------------------
interface mux_scan_seq_if #(
    parameter int SEL_W  = mux_scan_pkg::SEL_W,
    parameter int DATA_W = mux_scan_pkg::DATA_W
);

    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] mux_out;
    logic              smp_valid;
    logic              smp_ready;
    logic [DATA_W-1:0] smp_data;
    logic [SEL_W-1:0]  smp_idx;

    modport master (
        output sel,
        input  mux_out,
        output smp_valid,
        input  smp_ready,
        output smp_data,
        output smp_idx
    );

    modport slave (
        input  sel,
        output mux_out,
        input  smp_valid,
        output smp_ready,
        input  smp_data,
        input  smp_idx
    );

endinterface

// File: rtl/mux_scan_smp_reg.sv
// -----------------------------------------------------------------------------
// mux_scan_smp_reg
// Single-entry sample register with valid/ready hold logic.
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   load_i   capture data_i/idx_i and set valid
//   flush_i  drop the held sample without a transfer (wins over load_i)
//   ready_i  downstream accepts the held sample
//   data_i   value to capture
//   idx_i    index to capture
//   valid_o  register holds a sample
//   data_o   held value
//   idx_o    held index
// The payload only changes on load_i, so it is stable while valid_o=1 and
// ready_i=0 as long as the owner never loads into a stalled register.
// -----------------------------------------------------------------------------
module mux_scan_smp_reg #(
    parameter int SEL_W  = 5,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [SEL_W-1:0]  idx_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [SEL_W-1:0]  idx_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [SEL_W-1:0]  idx_q,   idx_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            idx_d   = idx_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;

endmodule

// File: rtl/mux_scan_seq.sv
// -----------------------------------------------------------------------------
// mux_scan_seq
// Select sequencer upstream of the NUM_INP:1 x DATA_W input mux. A start
// request sweeps sel over 0..NUM_INP-1, one index per accepted sample; each
// sample is offered downstream with valid/ready and also written into a packed
// snapshot for software readback.
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous active-high reset
//   start     one-cycle scan request, honoured only in IDLE
//   abort     terminates an active scan (wins over start and over capture)
//   bus       mux_scan_seq_if.master: sel, mux_out, smp_valid/ready/data/idx
//   busy      high in SCAN and DRAIN
//   done      one-cycle pulse at scan completion
//   snapshot  packed samples, bits [i*DATA_W +: DATA_W] hold input i
// Build option:
//   MUX_SCAN_CONT_EN  sweep continuously (wrap sel, pulse done per sweep)
//                     until abort; DRAIN is never entered.
// -----------------------------------------------------------------------------
module mux_scan_seq
    import mux_scan_pkg::*;
#(
    parameter int NUM_INP = mux_scan_pkg::NUM_INP,
    parameter int SEL_W   = mux_scan_pkg::SEL_W,
    parameter int DATA_W  = mux_scan_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    mux_scan_seq_if.master            bus,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_INP*DATA_W-1:0] snapshot
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_INP - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic             done_q,  done_d;

    logic              cap;
    logic              load;
    logic              flush;
    logic              smp_valid;
    logic [DATA_W-1:0] smp_data;
    logic [SEL_W-1:0]  smp_idx;

    // The register can take a new sample when empty or when its current
    // sample leaves on this edge.
    assign cap = !smp_valid || bus.smp_ready;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        load    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d = '0;
                if (!abort && start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                    sel_d   = '0;
                    flush   = 1'b1;
                end else if (cap) begin
                    load = 1'b1;
                    if (sel_q == LAST_SEL) begin
                        sel_d = '0;
`ifdef MUX_SCAN_CONT_EN
                        done_d = 1'b1;
`else
                        state_d = DRAIN;
`endif
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                sel_d = '0;
                if (abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (cap) begin
                    // Final sample is leaving (or already gone).
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                flush   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    mux_scan_smp_reg #(
        .SEL_W  (SEL_W),
        .DATA_W (DATA_W)
    ) u_smp_reg (
        .clk     (clk),
        .rst     (reset),
        .load_i  (load),
        .flush_i (flush),
        .ready_i (bus.smp_ready),
        .data_i  (bus.mux_out),
        .idx_i   (sel_q),
        .valid_o (smp_valid),
        .data_o  (smp_data),
        .idx_o   (smp_idx)
    );

    // One register per snapshot slot, written when its index is captured.
    logic [DATA_W-1:0] snap_q [NUM_INP];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INP; gi++) begin : g_slot
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    snap_q[gi] <= '0;
                end else if (load && (sel_q == SEL_W'(gi))) begin
                    snap_q[gi] <= bus.mux_out;
                end
            end
            assign snapshot[gi*DATA_W +: DATA_W] = snap_q[gi];
        end
    endgenerate

    assign bus.sel       = sel_q;
    assign bus.smp_valid = smp_valid;
    assign bus.smp_data  = smp_data;
    assign bus.smp_idx   = smp_idx;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule
